// File: rtl/pixel_stream_filter.sv
// Streaming RGB pixel filter: per-channel select, blend toward BG_LEVEL, optional horizontal mirror.
// Define PIXEL_FILTER_SAT_EN to make channel select 11 saturate instead of wrap.
module pixel_stream_filter #(
    parameter int                 PIX_W    = 8,
    parameter int                 LINE_LEN = 16,
    parameter logic [PIX_W-1:0]   BG_LEVEL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           r_value,
    input  logic [1:0]           g_value,
    input  logic [1:0]           b_value,
    input  logic [1:0]           t_value,
    input  logic                 o_value,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*PIX_W-1:0]   in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*PIX_W-1:0]   out_pixel,
    output logic                 out_last
);
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CW-1:0] LAST     = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(LINE_LEN - 2);

    typedef enum logic [1:0] {S_PASS, S_FILL, S_DRAIN} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, rd_idx;
    logic [1:0]           r_lat, g_lat, b_lat, t_lat;
    logic                 o_lat;
    logic [3*PIX_W-1:0]   line_buf [LINE_LEN];
    logic                 first, mirror_now, in_fire, out_fire;
    logic [1:0]           sel_r, sel_g, sel_b, sel_t;
    logic [3*PIX_W-1:0]   filt;

    function automatic logic [PIX_W-1:0] chan_sel(input logic [PIX_W-1:0] c, input logic [1:0] s);
        logic [PIX_W-1:0] res;
        case (s)
            2'b00:   res = '0;
            2'b01:   res = c >> 1;
            2'b10:   res = c;
            default: begin
`ifdef PIXEL_FILTER_SAT_EN
                res = c[PIX_W-1] ? '1 : PIX_W'({c, 1'b0});
`else
                res = PIX_W'({c, 1'b0});
`endif
            end
        endcase
        return res;
    endfunction

    function automatic logic [PIX_W-1:0] blend(input logic [PIX_W-1:0] c, input logic [1:0] t);
        logic [PIX_W+2:0] acc;
        acc = (PIX_W+3)'(c) * (PIX_W+3)'(3'd4 - {1'b0, t})
            + (PIX_W+3)'(BG_LEVEL) * (PIX_W+3)'(t);
        return PIX_W'(acc >> 2);
    endfunction

    // The first pixel of a line uses the live settings, which are captured on its handshake.
    assign first = (cnt == '0);
    assign sel_r = first ? r_value : r_lat;
    assign sel_g = first ? g_value : g_lat;
    assign sel_b = first ? b_value : b_lat;
    assign sel_t = first ? t_value : t_lat;

    assign filt = {blend(chan_sel(in_pixel[3*PIX_W-1:2*PIX_W], sel_r), sel_t),
                   blend(chan_sel(in_pixel[2*PIX_W-1:PIX_W],   sel_g), sel_t),
                   blend(chan_sel(in_pixel[PIX_W-1:0],         sel_b), sel_t)};

    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mirror_now = o_lat;
        in_fire    = 1'b0;
        case (state)
            S_PASS, S_FILL: begin
                mirror_now = first ? o_value : o_lat;
                // Filling only blocks if a pending pass pixel would be overwritten by the drain start.
                if (mirror_now)
                    in_ready = (cnt != LAST) || !out_valid || out_ready;
                else
                    in_ready = !out_valid || out_ready;
                in_fire = in_valid && in_ready;
                if (in_fire) begin
                    if (mirror_now && cnt == LAST) state_next = S_DRAIN;
                    else if (mirror_now)            state_next = S_FILL;
                    else                            state_next = S_PASS;
                end
            end
            default: begin
                if (out_fire && out_last)
                    state_next = o_value ? S_FILL : S_PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PASS;
            cnt       <= '0;
            rd_idx    <= '0;
            r_lat     <= '0;
            g_lat     <= '0;
            b_lat     <= '0;
            t_lat     <= '0;
            o_lat     <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (first) begin
                    r_lat <= r_value;
                    g_lat <= g_value;
                    b_lat <= b_value;
                    t_lat <= t_value;
                    o_lat <= o_value;
                end
            end
            if (state == S_DRAIN) begin
                if (out_fire) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        out_pixel <= line_buf[rd_idx];
                        out_last  <= (rd_idx == '0);
                        rd_idx    <= rd_idx - 1'b1;
                    end
                end
            end else if (in_fire && !mirror_now) begin
                out_valid <= 1'b1;
                out_pixel <= filt;
                out_last  <= (cnt == LAST);
            end else if (in_fire && cnt == LAST) begin
                // Last fill pixel goes straight to the output register as the first mirrored pixel.
                out_valid <= 1'b1;
                out_pixel <= filt;
                out_last  <= 1'b0;
                rd_idx    <= PRE_LAST;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && mirror_now)
            line_buf[cnt] <= filt;
    end
endmodule

// File: tb/tb_pixel_stream_filter.sv
// Scoreboard bench for pixel_stream_filter: two instances (BG_LEVEL 0 and 255) share all inputs.
module tb_pixel_stream_filter;
    localparam int PW = 8;
    localparam int LL = 16;
    localparam int W  = 3 * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    r_value, g_value, b_value, t_value;
    logic          o_value;
    logic          in_valid;
    logic [W-1:0]  in_pixel;
    logic          out_ready;
    logic          ready_req;
    logic          bp_en;
    logic          in_ready, out_valid, out_last;
    logic [W-1:0]  out_pixel;
    logic          in_ready_bg, out_valid_bg, out_last_bg;
    logic [W-1:0]  out_pixel_bg;

    logic [W:0]    exp_q[$];
    logic [W:0]    exp_bg_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [W-1:0]  line_px [LL];

    pixel_stream_filter #(.PIX_W(PW), .LINE_LEN(LL), .BG_LEVEL(8'd0)) dut (
        .clk(clk), .rst(rst),
        .r_value(r_value), .g_value(g_value), .b_value(b_value),
        .t_value(t_value), .o_value(o_value),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last)
    );

    pixel_stream_filter #(.PIX_W(PW), .LINE_LEN(LL), .BG_LEVEL(8'd255)) dut_bg (
        .clk(clk), .rst(rst),
        .r_value(r_value), .g_value(g_value), .b_value(b_value),
        .t_value(t_value), .o_value(o_value),
        .in_valid(in_valid), .in_ready(in_ready_bg), .in_pixel(in_pixel),
        .out_valid(out_valid_bg), .out_ready(out_ready),
        .out_pixel(out_pixel_bg), .out_last(out_last_bg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic int model_ch(input int c, input int s, input int t, input int bg);
        int v;
        case (s)
            0:       v = 0;
            1:       v = c / 2;
            2:       v = c;
`ifdef PIXEL_FILTER_SAT_EN
            default: v = (2 * c > 255) ? 255 : 2 * c;
`else
            default: v = (2 * c) % 256;
`endif
        endcase
        return ((4 - t) * v + t * bg) / 4;
    endfunction

    function automatic logic [W-1:0] model_px(input logic [W-1:0] p, input int r, input int g,
                                              input int b, input int t, input int bg);
        return {8'(model_ch(int'(p[23:16]), r, t, bg)),
                8'(model_ch(int'(p[15:8]),  g, t, bg)),
                8'(model_ch(int'(p[7:0]),   b, t, bg))};
    endfunction

    // out_ready changes at posedge+2; drivers change everything else at posedge+1.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_req;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) note_fail("dut_unexpected_out");
            else check("dut_out", {31'b0, out_last, out_pixel} & 32'h1ffffff, {7'b0, exp_q.pop_front()});
        end
        if (!rst && out_valid_bg && out_ready) begin
            if (exp_bg_q.size() == 0) note_fail("bg_unexpected_out");
            else check("bg_out", {7'b0, out_last_bg, out_pixel_bg}, {7'b0, exp_bg_q.pop_front()});
        end
    end

    task automatic send_pix(input logic [W-1:0] p, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        while (!in_ready && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) note_fail("in_ready_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int r, input int g, input int b, input int t, input logic o,
                             input int chg_at, input int new_r, input logic lat_chk,
                             input logic [W-1:0] lat_exp, input logic [W-1:0] lat_bg,
                             output int stall);
        int w;
        for (int i = 0; i < LL; i++) begin
            int idx;
            idx = o ? (LL - 1 - i) : i;
            exp_q.push_back({i == LL - 1, model_px(line_px[idx], r, g, b, t, 0)});
            exp_bg_q.push_back({i == LL - 1, model_px(line_px[idx], r, g, b, t, 255)});
        end
        r_value = 2'(r);
        g_value = 2'(g);
        b_value = 2'(b);
        t_value = 2'(t);
        o_value = o;
        stall = 0;
        for (int i = 0; i < LL; i++) begin
            send_pix(line_px[i], w);
            stall += w;
            if (i == 0 && lat_chk) begin
                check("pass_latency_valid", {31'b0, out_valid}, 32'd1);
                check("pass_latency_pixel", {8'b0, out_pixel}, {8'b0, lat_exp});
                check("pass_latency_bg", {8'b0, out_pixel_bg}, {8'b0, lat_bg});
            end
            if (i == chg_at) r_value = 2'(new_r);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic toggle, output int cycles, output int ready_hi);
        logic done;
        cycles = 0;
        ready_hi = 0;
        done = 1'b0;
        while (!done && cycles < 100) begin
            ready_req = toggle ? 1'(cycles % 2) : 1'b1;
            @(negedge clk);
            if (in_ready) ready_hi++;
            done = out_valid && out_ready && out_last;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) note_fail("drain_bound");
        ready_req = 1'b1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_bg_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, cyc, rh;
        rst = 1'b1;
        in_valid = 1'b1;
        in_pixel = 24'hABCDEF;
        r_value = 2'd0; g_value = 2'd0; b_value = 2'd0; t_value = 2'd0; o_value = 1'b0;
        ready_req = 1'b1;
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pixel", {8'b0, out_pixel}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        // PASS: r=10 g=00 b=01 t=00
        line_px[0] = {8'd200, 8'd100, 8'd50};
        for (int i = 1; i < LL; i++) line_px[i] = {8'(i * 13), 8'(i * 7 + 3), 8'(255 - i * 9)};
        send_line(2, 0, 1, 0, 1'b0, -1, 0, 1'b1, {8'd200, 8'd0, 8'd25}, {8'd200, 8'd0, 8'd25}, st);
        check("pass_stall", st, 0);

        // Select 11 on red
`ifdef PIXEL_FILTER_SAT_EN
        send_line(3, 2, 2, 0, 1'b0, -1, 0, 1'b1, {8'd255, 8'd100, 8'd50}, {8'd255, 8'd100, 8'd50}, st);
`else
        send_line(3, 2, 2, 0, 1'b0, -1, 0, 1'b1, {8'd144, 8'd100, 8'd50}, {8'd144, 8'd100, 8'd50}, st);
`endif

        // Blend t=10 and t=11
        line_px[0] = {8'd200, 8'd200, 8'd200};
        send_line(2, 2, 2, 2, 1'b0, -1, 0, 1'b1, {8'd100, 8'd100, 8'd100}, {8'd227, 8'd227, 8'd227}, st);
        send_line(2, 2, 2, 3, 1'b0, -1, 0, 1'b1, {8'd50, 8'd50, 8'd50}, {8'd241, 8'd241, 8'd241}, st);
        wait_empty();

        // Mirror with out_ready high, then with out_ready toggling
        for (int i = 0; i < LL; i++) line_px[i] = {8'(i), 8'(i + 16), 8'(i + 32)};
        send_line(2, 2, 2, 0, 1'b1, -1, 0, 1'b0, '0, '0, st);
        check("fill_stall", st, 0);
        drain(1'b0, cyc, rh);
        check("drain_cycles", cyc, 16);
        check("drain_in_ready", rh, 0);
        send_line(2, 2, 2, 0, 1'b1, -1, 0, 1'b0, '0, '0, st);
        check("fill2_stall", st, 0);
        drain(1'b1, cyc, rh);
        check("drain_toggle_cycles", cyc, 32);
        check("drain_toggle_in_ready", rh, 0);
        @(negedge clk);
        check("ready_after_drain", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Mid-line settings change, then next line with r=00 under backpressure
        for (int i = 0; i < LL; i++) line_px[i] = {8'(100 + i), 8'(i * 3), 8'(i * 5)};
        send_line(2, 2, 2, 0, 1'b0, 3, 0, 1'b0, '0, '0, st);
        bp_en = 1'b1;
        send_line(0, 2, 2, 0, 1'b0, -1, 0, 1'b0, '0, '0, st);
        bp_en = 1'b0;
        wait_empty();

        // Reset in the middle of a drain
        send_line(2, 1, 2, 1, 1'b1, -1, 0, 1'b0, '0, '0, st);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        ready_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_bg_q.delete();
        check("rst_drain_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_drain_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        ready_req = 1'b1;
        line_px[0] = {8'd200, 8'd100, 8'd50};
        send_line(2, 0, 1, 0, 1'b0, -1, 0, 1'b1, {8'd200, 8'd0, 8'd25}, {8'd200, 8'd0, 8'd25}, st);
        wait_empty();

        check("exp_q_empty", exp_q.size(), 0);
        check("exp_bg_q_empty", exp_bg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_stream_filter.md
# pixel_stream_filter

Parametrised streaming pixel-filter stage for the image processor datapath. It accepts packed RGB pixels over a valid/ready handshake. Per channel, it applies the user selections `r_value`, `g_value` and `b_value`, then blends toward a background level according to `t_value`. When `o_value` is set, it mirrors each line horizontally through an internal line buffer. All settings are latched once per line, so user changes never tear a line.

## Interface
- `PIX_W`, default 8: bits per colour channel.
- `LINE_LEN`, default 16: pixels per line; must be ≥ 2.
- `BG_LEVEL`, default 0: background channel value used by the transparency blend; `PIX_W` bits.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `r_value` in 2: red channel operation select.
- `g_value` in 2: green channel operation select.
- `b_value` in 2: blue channel operation select.
- `t_value` in 2: transparency level.
- `o_value` in 1: orientation; 0 = normal, 1 = horizontal mirror.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: block can accept a pixel.
- `in_pixel` in 3·`PIX_W`: packed as {R,G,B}; R occupies the MSBs.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: downstream accepts the output pixel.
- `out_pixel` out 3·`PIX_W`: processed pixel {R,G,B}.
- `out_last` out 1: qualifies the final output pixel of a line.

## Operation
- **Channel select**, for each channel c:
  - 00 → 0.
  - 01 → c>>1.
  - 10 → c.
  - 11 → c<<1, saturating or wrapping per Configuration.
- **Blend**: out = ((4−t)·c' + t·`BG_LEVEL`) >> 2.
  - Intermediate width is `PIX_W`+3; the result always fits in `PIX_W`.
  - Truncating division.
- **Setting latch**: `r/g/b/t/o_value` are captured on the handshake of the first pixel of each line (input pixel counter = 0).
  - They are used for the whole line.
  - Changes mid-line have no effect until the next line.
- **Input pixel counter**: counts 0..`LINE_LEN`−1 and wraps to 0 after the last pixel.
- **FSM states**:
  - PASS: normal orientation.
    - in_ready = !out_valid || out_ready.
    - The filtered pixel is registered into `out_pixel`.
    - out_last = 1 when the counter was `LINE_LEN`−1.
  - FILL: mirror mode.
    - in_ready = 1 and out_valid = 0.
    - The filtered pixel is written to buffer[index].
    - On the `LINE_LEN`-th pixel, go to DRAIN.
  - DRAIN: in_ready = 0.
    - Emits buffer[`LINE_LEN`−1] down to buffer[0].
    - out_last is asserted with buffer[0].
    - On the handshake of that final pixel, go to FILL or PASS according to the next line's latched `o_value`.
- **Line-start state choice**: at a line start, the state is chosen from the live `o_value`.
  - PASS and FILL are equivalent while idle, and select at the first handshake.
- **Output hold**: out_pixel and out_last hold stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid = 0, out_pixel = 0, out_last = 0.
  - in_ready = 1.
  - State = PASS, pixel counter = 0, output counter = 0, latched settings = 0.
- Reset mid-line or mid-DRAIN discards the buffer contents and all partial-line state on the next edge.
- PASS latency is 1 cycle (accept at edge N, out_valid from edge N).
  - Throughput is one pixel per cycle with out_ready held high.
- Mirror:
  - The first output is valid the cycle after the `LINE_LEN`-th input handshake.
  - DRAIN lasts `LINE_LEN` cycles with out_ready high.
  - Line period is 2·`LINE_LEN` cycles.
- Simultaneous out handshake and in handshake in PASS: the new pixel replaces the old one in the same cycle, with no bubble.
- Transition from DRAIN to FILL: in_ready rises in the cycle after the final out handshake.
- Transition from PASS to FILL at a line boundary: no extra cycle.

## Configuration
- `PIXEL_FILTER_SAT_EN` defined: select 11 saturates, min(2c, 2^`PIX_W`−1).
- `PIXEL_FILTER_SAT_EN` undefined: select 11 wraps, (2c) mod 2^`PIX_W`.
- The macro affects nothing else.

## Test plan
1. Reset: hold rst high for 2 cycles with in_valid = 1 → out_valid = 0, out_pixel = 0, out_last = 0, in_ready = 1.
2. PASS mode:
   - Settings: r=10, g=00, b=01, t=00, o=0, `PIX_W`=8.
   - Input {200,100,50} → {200,0,25} valid one cycle later.
   - 16 back-to-back pixels give 16 outputs; out_last is set on the 16th only.
3. Select 11 on R, input R=200:
   - `PIXEL_FILTER_SAT_EN` defined → 255.
   - Undefined → 144.
4. Blend: r=g=b=10, t=10, `BG_LEVEL`=0, input {200,200,200} → {100,100,100}.
   - With t=11 and `BG_LEVEL`=255 → {241,241,241}.
5. Mirror: o=1, `LINE_LEN`=16, R = 0..15.
   - in_ready stays 1 for 16 cycles.
   - Outputs R = 15..0; out_last is set with R=0.
   - in_ready is 0 throughout DRAIN.
   - out_ready toggling every other cycle stretches DRAIN to 32 cycles with order preserved.
6. Mid-line change and reset:
   - Switching r_value 10→00 after pixel 3 leaves that line's R unchanged.
   - The next line's R is 0.
   - Asserting rst during DRAIN → out_valid = 0 next cycle; a new line then passes correctly.
